// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: multi-floor elevator controller with latched requests,
// SCAN scheduling (keep going while work lies ahead, then reverse), timed
// floor-to-floor travel and timed door dwell. All outputs come straight from
// flops so the motor/door drivers never see combinational glitches.
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  door_open,
  output logic                  moving,
  output logic                  dir_up,
  output logic                  arrived,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TRV_W = $clog2(TRAVEL_CYCLES + 1);
  localparam int DR_W  = $clog2(DOOR_CYCLES + 1);
  localparam logic [FLOOR_W:0]   NUM_FLOORS_C = (FLOOR_W+1)'(NUM_FLOORS);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR_C  = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] BOT_FLOOR_C  = {FLOOR_W{1'b0}};
  localparam logic [TRV_W-1:0]   TRV_LAST_C   = TRV_W'(TRAVEL_CYCLES - 1);
  localparam logic [DR_W-1:0]    DOOR_LAST_C  = DR_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [FLOOR_W-1:0]      floor_r, floor_s;
  logic [NUM_FLOORS-1:0]   pend_r, pend_s;
  logic                    dir_up_r, dir_up_s;
  logic                    door_r, door_s;
  logic                    moving_r, moving_s;
  logic                    arrived_r, arrived_s;
  logic [TRV_W-1:0]        trv_cnt_r, trv_cnt_s;
  logic [DR_W-1:0]         door_cnt_r, door_cnt_s;

  logic                    req_ok_s;
  logic [FLOOR_W-1:0]      step_floor_s;
  logic [NUM_FLOORS-1:0]   set_mask_s;
  logic [NUM_FLOORS-1:0]   clr_mask_s;

  // One-hot vector selecting floor f (all zero if f is out of range).
  function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] v;
    v = {NUM_FLOORS{1'b0}};
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) == f) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  // Any request strictly above floor f.
  function automatic logic any_above(input logic [NUM_FLOORS-1:0] v,
                                     input logic [FLOOR_W-1:0]    f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (v[i] && (FLOOR_W'(i) > f)) begin
        r = 1'b1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Any request strictly below floor f.
  function automatic logic any_below(input logic [NUM_FLOORS-1:0] v,
                                     input logic [FLOOR_W-1:0]    f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (v[i] && (FLOOR_W'(i) < f)) begin
        r = 1'b1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Next-state, next-output and request bookkeeping for the scheduler.
  always_comb begin
    state_s      = state_r;
    floor_s      = floor_r;
    dir_up_s     = dir_up_r;
    door_s       = door_r;
    moving_s     = moving_r;
    arrived_s    = 1'b0;
    trv_cnt_s    = trv_cnt_r;
    door_cnt_s   = door_cnt_r;
    clr_mask_s   = {NUM_FLOORS{1'b0}};
    set_mask_s   = {NUM_FLOORS{1'b0}};
    step_floor_s = floor_r;

    req_ok_s = req_valid && ({1'b0, req_floor} < NUM_FLOORS_C);

    // The floor the car reaches when the current hop completes; clamped so
    // the index can never leave the building even if the schedule were wrong.
    if (dir_up_r && (floor_r != TOP_FLOOR_C)) begin
      step_floor_s = floor_r + FLOOR_W'(1);
    end else if (!dir_up_r && (floor_r != BOT_FLOOR_C)) begin
      step_floor_s = floor_r - FLOOR_W'(1);
    end else begin
      step_floor_s = floor_r;
    end

    // A repeat press for the floor whose door is already open only extends the
    // dwell; it must not leave a stale request behind.
    if (req_ok_s && !((state_r == ST_DOOR) && (req_floor == floor_r))) begin
      set_mask_s = floor_bit(req_floor);
    end else begin
      set_mask_s = {NUM_FLOORS{1'b0}};
    end

    case (state_r)
      ST_IDLE: begin
        if (|(pend_r & floor_bit(floor_r))) begin
          state_s    = ST_DOOR;
          clr_mask_s = floor_bit(floor_r);
          arrived_s  = 1'b1;
          door_s     = 1'b1;
          moving_s   = 1'b0;
          door_cnt_s = {DR_W{1'b0}};
        end else if (dir_up_r ? any_above(pend_r, floor_r) : any_below(pend_r, floor_r)) begin
          state_s   = ST_MOVE;
          moving_s  = 1'b1;
          trv_cnt_s = {TRV_W{1'b0}};
        end else if (dir_up_r ? any_below(pend_r, floor_r) : any_above(pend_r, floor_r)) begin
          state_s   = ST_MOVE;
          moving_s  = 1'b1;
          trv_cnt_s = {TRV_W{1'b0}};
          dir_up_s  = ~dir_up_r;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_MOVE: begin
        if (trv_cnt_r == TRV_LAST_C) begin
          trv_cnt_s = {TRV_W{1'b0}};
          floor_s   = step_floor_s;
          if (|(pend_r & floor_bit(step_floor_s))) begin
            state_s    = ST_DOOR;
            clr_mask_s = floor_bit(step_floor_s);
            arrived_s  = 1'b1;
            door_s     = 1'b1;
            moving_s   = 1'b0;
            door_cnt_s = {DR_W{1'b0}};
          end else if (dir_up_r ? any_above(pend_r, step_floor_s)
                                : any_below(pend_r, step_floor_s)) begin
            state_s = ST_MOVE;
          end else if (dir_up_r ? any_below(pend_r, step_floor_s)
                                : any_above(pend_r, step_floor_s)) begin
            state_s  = ST_MOVE;
            dir_up_s = ~dir_up_r;
          end else begin
            state_s  = ST_IDLE;
            moving_s = 1'b0;
          end
        end else begin
          trv_cnt_s = trv_cnt_r + TRV_W'(1);
        end
      end

      ST_DOOR: begin
        if (req_ok_s && (req_floor == floor_r)) begin
          door_cnt_s = {DR_W{1'b0}};
        end else if (door_cnt_r == DOOR_LAST_C) begin
          state_s    = ST_IDLE;
          door_s     = 1'b0;
          door_cnt_s = {DR_W{1'b0}};
        end else begin
          door_cnt_s = door_cnt_r + DR_W'(1);
        end
      end

      default: begin
        state_s    = ST_IDLE;
        door_s     = 1'b0;
        moving_s   = 1'b0;
        trv_cnt_s  = {TRV_W{1'b0}};
        door_cnt_s = {DR_W{1'b0}};
      end
    endcase

    // Clearing the serviced floor wins over a new press for it on the same edge.
    pend_s = (pend_r | set_mask_s) & ~clr_mask_s;
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      floor_r    <= {FLOOR_W{1'b0}};
      pend_r     <= {NUM_FLOORS{1'b0}};
      dir_up_r   <= 1'b1;
      door_r     <= 1'b0;
      moving_r   <= 1'b0;
      arrived_r  <= 1'b0;
      trv_cnt_r  <= {TRV_W{1'b0}};
      door_cnt_r <= {DR_W{1'b0}};
    end else begin
      state_r    <= state_s;
      floor_r    <= floor_s;
      pend_r     <= pend_s;
      dir_up_r   <= dir_up_s;
      door_r     <= door_s;
      moving_r   <= moving_s;
      arrived_r  <= arrived_s;
      trv_cnt_r  <= trv_cnt_s;
      door_cnt_r <= door_cnt_s;
    end
  end

  assign current_floor = floor_r;
  assign door_open     = door_r;
  assign moving        = moving_r;
  assign dir_up        = dir_up_r;
  assign arrived       = arrived_r;
  assign pending       = pend_r;

endmodule
